rvc_fetch_align_buffer: RTL and testbench
=========================================

Name: rvc_fetch_align_buffer

Overview:
Parametrised fetch-side realigner for the RV32IC core, sitting between instruction memory and decode. It replaces the single-halfword stall/concatenate scheme with a halfword FIFO. Pipelined word fetches continue while 32-bit instructions that straddle word boundaries are assembled, and 16-bit compressed instructions are extracted. On redirect (jump/branch) the buffer is flushed and fetch restarts at any halfword-aligned PC; in-flight stale responses are discarded. Decode receives one aligned instruction per cycle with its PC through a valid/ready handshake.

Parameters:
FETCH_HW, 2, halfwords per fetch word (2 = 32-bit imem, 4 = 64-bit imem); power of two.
BUF_HW, 8, FIFO depth in halfwords; power of two, at least 2*FETCH_HW.
MAX_OUTST, 2, maximum outstanding imem requests (1..4).
RESET_PC, 32'h0000_0000, PC after reset.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
redirect_i  in  1  flush and restart fetch at redirect_pc_i
redirect_pc_i  in  32  new PC; bit0 is ignored
req_o  in/out: out  1  imem request valid
req_addr_o  out  32  fetch address, aligned to FETCH_HW*2 bytes
gnt_i  in  1  imem accepts the request (req_o & gnt_i = issued)
rvalid_i  in  1  response valid; responses arrive in issue order, latency ≥1 cycle
rdata_i  in  16*FETCH_HW  response word; halfword 0 = lowest address
inst_valid_o  out  1  inst_o holds a complete instruction
inst_ready_i  in  1  decode accepts
inst_o  out  32  instruction; compressed instructions are zero-extended in [31:16]
inst_pc_o  out  32  PC of inst_o
inst_is_c_o  out  1  inst_o is 16-bit compressed

Behaviour:
- Reset values: req_o=0, req_addr_o=RESET_PC aligned down, inst_valid_o=0, inst_o=0, inst_pc_o=RESET_PC, inst_is_c_o=0. After reset the FIFO is empty, outstanding=0, kill=0, and skip = RESET_PC[log2(2*FETCH_HW)-1:1].
- Registers:
  - halfword FIFO: rd/wr pointers with an extra wrap bit, and a count.
  - fetch_addr, head_pc.
  - outstanding counter and kill counter (0..MAX_OUTST).
  - skip (number of halfwords to drop from the first valid response after a redirect).
- Request issue: req_o = ~redirect_i & (outstanding < MAX_OUTST) & (BUF_HW - count ≥ FETCH_HW*(outstanding+1)). No request may be issued whose response could overflow the FIFO.
- On req_o & gnt_i: fetch_addr += 2*FETCH_HW (wraps modulo 2^32) and outstanding increments. outstanding decrements on rvalid_i. A grant and a response in the same cycle leave outstanding unchanged.
- Response handling:
  - If kill>0, the response is dropped and kill decrements.
  - Otherwise halfwords skip..FETCH_HW-1 are written at wr_ptr in ascending order, and skip is cleared to 0.
  - Pointers wrap modulo BUF_HW.
- Output (combinational from FIFO state, zero added latency):
  - head = FIFO[rd_ptr].
  - If count≥1 and head[1:0]≠2'b11: inst_valid_o=1, inst_is_c_o=1, inst_o={16'b0, head}.
  - If count≥2 and head[1:0]==2'b11: inst_valid_o=1, inst_is_c_o=0, inst_o={FIFO[rd_ptr+1], head}. This is the misaligned/straddling case; no stall bubble and no NOP injection.
  - Otherwise inst_valid_o=0. inst_o and inst_is_c_o hold their last values.
  - inst_pc_o=head_pc.
- Consume on inst_valid_o & inst_ready_i & ~redirect_i:
  - rd_ptr advances by 1 (compressed) or 2 (full).
  - head_pc advances by 2 or 4.
- A consume and a response write in the same cycle update count by (written − consumed).
- Redirect (has priority over everything in its cycle):
  - FIFO is emptied and head_pc=redirect_pc_i with bit0 forced to 0.
  - fetch_addr = redirect_pc_i aligned down; skip = its halfword offset within the fetch word.
  - kill = outstanding − (rvalid_i this cycle ? 1 : 0). A response arriving in the redirect cycle is dropped.
  - req_o is 0 in the redirect cycle. The consume handshake in that cycle is ignored.
- Back-to-back redirects: each one overrides the previous, and kill accumulates correctly from the outstanding count.
- Reset mid-operation: returns to reset values. Responses to requests issued before reset are not tracked; the imem is reset by the same signal.
- Full: no request is issued and the FIFO never overflows.
- Empty, or a lone 32-bit lower half: inst_valid_o=0.

Test Plan:
- Reset, RESET_PC=0, words 0x00A00093, 0x00108113 with 1-cycle grant/response → two full instructions at PC 0x0 and 0x4, inst_is_c_o=0, back-to-back with no bubble once the FIFO is primed.
- Word 0x4501_4081 (two compressed) → inst_o=0x00004081 at PC 0, then 0x00004501 at PC 2, both with inst_is_c_o=1.
- Straddle case: words 0x0093_4081 then 0x1234_00A0 → 0x4081 at PC 0, then 0x00A00093 at PC 2 (full, concatenated across words), then halfword 0x1234 is waiting.
- Redirect to 0x102 with 2 outstanding → both stale responses dropped. Fetch restarts at 0x100, halfword 0 of the first response is skipped, and the first output PC is 0x102.
- inst_ready_i held low for 20 cycles → FIFO fills to BUF_HW and req_o deasserts with no overflow. On release, instructions drain in order and requests resume.
- Redirect in the same cycle as rvalid_i and inst_ready_i → that response is discarded, no consume happens, and the next inst_pc_o equals redirect_pc_i.

Source files
------------

// File: rtl/rvc_fetch_align_buffer.sv
// Fetch realigner: buffers imem words as halfwords and presents one aligned RV32IC
// instruction per cycle to decode, handling redirects and stale in-flight responses.
module rvc_fetch_align_buffer #(
    parameter int          FETCH_HW  = 2,
    parameter int          BUF_HW    = 8,
    parameter int          MAX_OUTST = 2,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  redirect_i,
    input  logic [31:0]           redirect_pc_i,
    output logic                  req_o,
    output logic [31:0]           req_addr_o,
    input  logic                  gnt_i,
    input  logic                  rvalid_i,
    input  logic [16*FETCH_HW-1:0] rdata_i,
    output logic                  inst_valid_o,
    input  logic                  inst_ready_i,
    output logic [31:0]           inst_o,
    output logic [31:0]           inst_pc_o,
    output logic                  inst_is_c_o
);
    localparam int          PW         = $clog2(BUF_HW);
    localparam int          OFF_W      = $clog2(2 * FETCH_HW);
    localparam int          SW         = OFF_W - 1;
    localparam logic [31:0] ALIGN_MASK = ~(32'(2 * FETCH_HW) - 32'd1);
    localparam logic [PW:0] ONE        = (PW+1)'(1);
    localparam logic [PW:0] TWO        = (PW+1)'(2);

    logic [15:0]    fifo [BUF_HW];
    logic [PW:0]    rd_ptr, wr_ptr, count;
    logic [31:0]    fetch_addr, head_pc;
    logic [2:0]     outst, kill;
    logic [SW-1:0]  skip;
    logic [31:0]    last_inst;
    logic           last_is_c;

    logic [15:0]    head;
    logic [PW-1:0]  rd_idx1;
    logic           head_full;
    logic [31:0]    cur_inst;
    logic [31:0]    free_hw, need_hw;
    logic           issue, take, consume;
    logic [PW:0]    n_wr, n_rd;

    assign head      = fifo[rd_ptr[PW-1:0]];
    assign rd_idx1   = rd_ptr[PW-1:0] + PW'(1);
    assign head_full = &head[1:0];
    assign cur_inst  = head_full ? {fifo[rd_idx1], head} : {16'h0000, head};

    assign inst_valid_o = head_full ? (count >= TWO) : (count >= ONE);
    assign inst_o       = inst_valid_o ? cur_inst : last_inst;
    assign inst_is_c_o  = inst_valid_o ? ~head_full : last_is_c;
    assign inst_pc_o    = head_pc;
    assign req_addr_o   = fetch_addr;

    // Reserve FIFO space for every response still in flight plus the new one.
    assign free_hw = 32'(BUF_HW) - 32'(count);
    assign need_hw = 32'(FETCH_HW) * (32'(outst) + 32'd1);
    assign req_o   = ~reset & ~redirect_i & (32'(outst) < 32'(MAX_OUTST)) & (free_hw >= need_hw);

    assign issue   = req_o & gnt_i;
    assign take    = rvalid_i & ~redirect_i & (kill == 3'd0);
    assign consume = inst_valid_o & inst_ready_i & ~redirect_i;
    assign n_wr    = (PW+1)'(FETCH_HW) - (PW+1)'(skip);
    assign n_rd    = head_full ? TWO : ONE;

    // Halfword storage: leading halfwords of the first word after a redirect are dropped.
    always_ff @(posedge clk) begin
        if (take) begin
            for (int i = 0; i < FETCH_HW; i++) begin
                if (i >= int'(skip))
                    fifo[PW'(wr_ptr[PW-1:0] + PW'(i) - PW'(skip))] <= rdata_i[16*i +: 16];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            fetch_addr <= RESET_PC & ALIGN_MASK;
            head_pc    <= {RESET_PC[31:1], 1'b0};
            outst      <= 3'd0;
            kill       <= 3'd0;
            skip       <= RESET_PC[OFF_W-1:1];
            last_inst  <= 32'h0;
            last_is_c  <= 1'b0;
        end else begin
            if (inst_valid_o) begin
                last_inst <= cur_inst;
                last_is_c <= ~head_full;
            end
            if (redirect_i) begin
                // Everything still in flight becomes stale; a response landing now is one of them.
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                count      <= '0;
                head_pc    <= {redirect_pc_i[31:1], 1'b0};
                fetch_addr <= redirect_pc_i & ALIGN_MASK;
                skip       <= redirect_pc_i[OFF_W-1:1];
                kill       <= outst - {2'b00, rvalid_i};
                outst      <= outst - {2'b00, rvalid_i};
            end else begin
                if (issue)
                    fetch_addr <= fetch_addr + 32'(2 * FETCH_HW);
                outst <= outst + {2'b00, issue} - {2'b00, rvalid_i};
                if (rvalid_i && kill != 3'd0)
                    kill <= kill - 3'd1;
                if (take) begin
                    wr_ptr <= wr_ptr + n_wr;
                    skip   <= '0;
                end
                if (consume) begin
                    rd_ptr  <= rd_ptr + n_rd;
                    head_pc <= head_pc + (head_full ? 32'd4 : 32'd2);
                end
                count <= count + (take ? n_wr : '0) - (consume ? n_rd : '0);
            end
        end
    end
endmodule

// File: tb/tb_rvc_fetch_align_buffer.sv
// Bench for rvc_fetch_align_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations on the accepted instruction stream.
module tb_rvc_fetch_align_buffer;
    localparam int          FHW = 2;
    localparam int          BHW = 8;
    localparam int          MO  = 2;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic              clk;
    logic              reset;
    logic              redirect_i;
    logic [31:0]       redirect_pc_i;
    logic              req_o;
    logic [31:0]       req_addr_o;
    logic              gnt_i;
    logic              rvalid_i;
    logic [16*FHW-1:0] rdata_i;
    logic              inst_valid_o;
    logic              inst_ready_i;
    logic [31:0]       inst_o;
    logic [31:0]       inst_pc_o;
    logic              inst_is_c_o;

    rvc_fetch_align_buffer #(.FETCH_HW(FHW), .BUF_HW(BHW), .MAX_OUTST(MO), .RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .req_o(req_o), .req_addr_o(req_addr_o), .gnt_i(gnt_i), .rvalid_i(rvalid_i),
        .rdata_i(rdata_i), .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
        .inst_o(inst_o), .inst_pc_o(inst_pc_o), .inst_is_c_o(inst_is_c_o)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    // Test control, read by the driver on each falling edge
    logic        ctl_reset    = 1'b1;
    logic        ctl_redirect = 1'b0;
    logic [31:0] ctl_pc       = 32'h0;
    logic        ctl_ready    = 1'b0;
    logic        ctl_gnt      = 1'b1;
    logic        ctl_resp_en  = 1'b1;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] iq [$];

    function automatic logic [31:0] mem_rd(logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0001_0001;
    endfunction

    // Reference model: halfword queue plus one stale flag per pending request
    logic [15:0] mq [$];
    bit          pend [$];
    logic [31:0] m_head_pc, m_fetch, m_last;
    bit          m_last_c;
    int          m_skip;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        is_c;
        int          cyc;
    } acc_t;
    acc_t acc [$];

    int cycle = 0;
    int n_tests = 0;
    int n_fail = 0;
    int n_issue = 0;
    int rdr_mark = 0;
    bit rdr_rv = 0;
    bit rdr_iv = 0;

    task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cycle, act, exp);
        end
    endtask

    task automatic chk_acc(string name, int i, logic [31:0] inst, logic [31:0] pc, logic c);
        if (i >= acc.size()) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: instruction %0d never accepted (have %0d)", name, i, acc.size());
        end else begin
            check32({name, ".inst"}, acc[i].inst, inst);
            check32({name, ".pc"}, acc[i].pc, pc);
            check32({name, ".is_c"}, {31'b0, acc[i].is_c}, {31'b0, c});
        end
    endtask

    function automatic void m_init();
        mq.delete();
        pend.delete();
        m_head_pc = {RPC[31:1], 1'b0};
        m_fetch   = RPC & ~32'(2*FHW - 1);
        m_skip    = int'(RPC[1]);
        m_last    = 32'h0;
        m_last_c  = 1'b0;
    endfunction

    always @(negedge clk) begin
        bit          e_v, e_full, e_req;
        logic [31:0] e_inst;
        bit          e_c;
        reset         = ctl_reset;
        redirect_i    = ctl_redirect;
        redirect_pc_i = ctl_pc;
        inst_ready_i  = ctl_ready;
        gnt_i         = ctl_gnt;
        if (ctl_reset) begin
            iq.delete();
            rvalid_i = 1'b0;
            rdata_i  = '0;
            m_init();
        end else begin
            if (ctl_resp_en && iq.size() > 0) begin
                rvalid_i = 1'b1;
                rdata_i  = mem_rd(iq.pop_front());
            end else begin
                rvalid_i = 1'b0;
                rdata_i  = '0;
            end
            #1;
            e_full = mq.size() > 0 && mq[0][1:0] == 2'b11;
            e_v    = mq.size() >= (e_full ? 2 : 1);
            e_inst = e_v ? (e_full ? {mq[1], mq[0]} : {16'h0, mq[0]}) : m_last;
            e_c    = e_v ? !e_full : m_last_c;
            e_req  = !ctl_redirect && pend.size() < MO && (BHW - mq.size() >= FHW * (pend.size() + 1));
            check32("req_o", {31'b0, req_o}, {31'b0, e_req});
            check32("req_addr_o", req_addr_o, m_fetch);
            check32("inst_valid_o", {31'b0, inst_valid_o}, {31'b0, e_v});
            check32("inst_o", inst_o, e_inst);
            check32("inst_is_c_o", {31'b0, inst_is_c_o}, {31'b0, e_c});
            check32("inst_pc_o", inst_pc_o, m_head_pc);

            if (ctl_redirect) begin
                rdr_mark = acc.size();
                rdr_rv   = rvalid_i;
                rdr_iv   = inst_valid_o;
            end else if (inst_valid_o && inst_ready_i) begin
                acc.push_back('{inst: inst_o, pc: inst_pc_o, is_c: inst_is_c_o, cyc: cycle});
            end
            if (req_o && gnt_i) begin
                iq.push_back(req_addr_o);
                n_issue++;
            end

            if (e_v) begin
                m_last   = e_inst;
                m_last_c = e_c;
            end
            if (ctl_redirect) begin
                if (rvalid_i && pend.size() > 0) void'(pend.pop_front());
                foreach (pend[k]) pend[k] = 1'b1;
                mq.delete();
                m_head_pc = {ctl_pc[31:1], 1'b0};
                m_fetch   = ctl_pc & ~32'(2*FHW - 1);
                m_skip    = int'(ctl_pc[1]);
            end else begin
                if (e_v && ctl_ready) begin
                    void'(mq.pop_front());
                    if (e_full) void'(mq.pop_front());
                    m_head_pc += e_full ? 32'd4 : 32'd2;
                end
                if (rvalid_i && pend.size() > 0) begin
                    if (!pend.pop_front()) begin
                        for (int i = m_skip; i < FHW; i++) mq.push_back(rdata_i[16*i +: 16]);
                        m_skip = 0;
                        if (mq.size() > BHW) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL overflow (cycle %0d): %0d halfwords buffered, limit %0d", cycle, mq.size(), BHW);
                        end
                    end
                end
                if (e_req && ctl_gnt) begin
                    pend.push_back(1'b0);
                    m_fetch += 32'(2*FHW);
                end
            end
        end
        cycle++;
    end

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic do_reset();
        ctl_reset = 1'b1;
        ctl_redirect = 1'b0;
        cyc(2);
        acc.delete();
        ctl_reset = 1'b0;
    endtask

    task automatic wait_acc(int n, string name);
        int t = 0;
        while (acc.size() < n && t < 300) begin
            @(posedge clk);
            t++;
        end
        n_tests++;
        if (acc.size() < n) begin
            n_fail++;
            $display("FAIL %s: %0d instructions accepted, needed %0d", name, acc.size(), n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int save;
        // Reset state
        ctl_reset = 1'b1;
        cyc(2);
        #1;
        check32("reset.req_o", {31'b0, req_o}, 32'd0);
        check32("reset.req_addr_o", req_addr_o, 32'h0);
        check32("reset.inst_valid_o", {31'b0, inst_valid_o}, 32'd0);
        check32("reset.inst_o", inst_o, 32'h0);
        check32("reset.inst_pc_o", inst_pc_o, RPC);
        check32("reset.inst_is_c_o", {31'b0, inst_is_c_o}, 32'd0);

        // Two aligned full instructions, back to back
        mem.delete();
        mem[32'h0] = 32'h00A0_0093;
        mem[32'h4] = 32'h0010_8113;
        ctl_ready = 1'b1;
        do_reset();
        wait_acc(2, "t1");
        chk_acc("t1.i0", 0, 32'h00A0_0093, 32'h0, 1'b0);
        chk_acc("t1.i1", 1, 32'h0010_8113, 32'h4, 1'b0);
        if (acc.size() >= 2) check32("t1.no_bubble", 32'(acc[1].cyc - acc[0].cyc), 32'd1);

        // Two compressed instructions in one word
        mem.delete();
        mem[32'h0] = 32'h4501_4081;
        do_reset();
        wait_acc(2, "t2");
        chk_acc("t2.i0", 0, 32'h0000_4081, 32'h0, 1'b1);
        chk_acc("t2.i1", 1, 32'h0000_4501, 32'h2, 1'b1);

        // Full instruction straddling a word boundary
        mem.delete();
        mem[32'h0] = 32'h0093_4081;
        mem[32'h4] = 32'h1234_00A0;
        do_reset();
        wait_acc(3, "t3");
        chk_acc("t3.i0", 0, 32'h0000_4081, 32'h0, 1'b1);
        chk_acc("t3.i1", 1, 32'h00A0_0093, 32'h2, 1'b0);
        chk_acc("t3.i2", 2, 32'h0000_1234, 32'h6, 1'b1);

        // Redirect to a misaligned PC with two requests in flight
        mem.delete();
        mem[32'h0]   = 32'h0002_0002;
        mem[32'h4]   = 32'h0003_0003;
        mem[32'h100] = 32'h4505_4081;
        ctl_resp_en = 1'b0;
        do_reset();
        cyc(3);
        #1;
        check32("t4.req_limit", {31'b0, req_o}, 32'd0);
        ctl_redirect = 1'b1;
        ctl_pc = 32'h0000_0102;
        cyc(1);
        ctl_redirect = 1'b0;
        ctl_resp_en = 1'b1;
        wait_acc(2, "t4");
        chk_acc("t4.i0", 0, 32'h0000_4505, 32'h102, 1'b1);
        chk_acc("t4.i1", 1, 32'h0000_0001, 32'h104, 1'b1);

        // Decode stalled: buffer fills, requests stop, then drain in order
        mem.delete();
        ctl_ready = 1'b0;
        do_reset();
        cyc(20);
        #1;
        check32("t5.full_req_o", {31'b0, req_o}, 32'd0);
        check32("t5.model_fill", 32'(mq.size()), 32'(BHW));
        check32("t5.head_pc", inst_pc_o, 32'h0);
        save = n_issue;
        ctl_ready = 1'b1;
        wait_acc(10, "t5");
        for (int k = 0; k < 10; k++) chk_acc("t5.drain", k, 32'h0000_0001, 32'(2*k), 1'b1);
        n_tests++;
        if (n_issue <= save) begin
            n_fail++;
            $display("FAIL t5.req_resume: issued %0d after release, required more than %0d", n_issue, save);
        end

        // Redirect coinciding with a response and a consume
        mem.delete();
        for (int a = 0; a < 64; a += 4) mem[32'(a)] = 32'h0000_0013;
        mem[32'h200] = 32'h0000_4511;
        ctl_ready = 1'b1;
        do_reset();
        cyc(6);
        ctl_redirect = 1'b1;
        ctl_pc = 32'h0000_0200;
        cyc(1);
        ctl_redirect = 1'b0;
        check32("t6.rvalid_in_redirect", {31'b0, rdr_rv}, 32'd1);
        check32("t6.valid_in_redirect", {31'b0, rdr_iv}, 32'd1);
        wait_acc(rdr_mark + 1, "t6");
        chk_acc("t6.first", rdr_mark, 32'h0000_4511, 32'h200, 1'b1);

        cyc(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
